// File: rtl/dm_bus_agent_if.sv
// dm_bus_agent_if: req/gnt/rvalid data bus between the MEM-stage agent and the system bridge
interface dm_bus_agent_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  modport master (
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dm_bus_agent.sv
// dm_bus_agent: checks MEM-stage accesses for faults and runs them as stalling req/gnt/rvalid bus transactions
module dm_bus_agent #(
  parameter logic [31:0] DM_END       = 32'h0000_2fff,
  parameter logic [31:0] TC0_BASE     = 32'h0000_7f00,
  parameter logic [31:0] TC1_BASE     = 32'h0000_7f10,
  parameter logic [31:0] INT_BASE     = 32'h0000_7f20,
  parameter int          TIMEOUT      = 16,
  parameter int          CNT_W        = $clog2(TIMEOUT + 1),
  parameter logic [3:0]  MEMWORD      = 4'd0,
  parameter logic [3:0]  MEMHALFWORD  = 4'd1,
  parameter logic [3:0]  MEMHALFWORDU = 4'd2,
  parameter logic [3:0]  MEMBYTE      = 4'd3,
  parameter logic [3:0]  MEMBYTEU     = 4'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [3:0]           MemType,
  input  logic [31:0]          Addr,
  input  logic [31:0]          WD,
  input  logic                 WE,
  input  logic                 requestInt,
  output logic                 stall,
  output logic [31:0]          RD,
  output logic                 rd_valid,
  output logic [4:0]           excCode,
  dm_bus_agent_if.master       bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]         type_q, type_d, be_q, be_d;
  logic               we_q, we_d, err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_half, is_byte, is_tc, in_range, fault, timeout;
  logic [3:0]         be;
  logic [31:0]        wd_sh, ld_ext;
  logic [15:0]        lane;
  assign is_half  = MemType == MEMHALFWORD || MemType == MEMHALFWORDU;
  assign is_byte  = MemType == MEMBYTE || MemType == MEMBYTEU;
  assign is_tc    = Addr[31:4] == TC0_BASE[31:4] || Addr[31:4] == TC1_BASE[31:4];
  assign in_range = Addr <= DM_END || is_tc || Addr[31:2] == INT_BASE[31:2];
  // timers: word-only, offset 0xC absent, offset 0x8 read-only
  assign fault = (!is_half && !is_byte && Addr[1:0] != 2'b00) || (is_half && Addr[0]) || !in_range ||
                 (is_tc && (is_half || is_byte || Addr[3:2] == 2'b11 || (Addr[3:2] == 2'b10 && WE)));
  assign be    = is_byte ? 4'b0001 << Addr[1:0] : is_half ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_sh = (is_byte ? {24'b0, WD[7:0]} : is_half ? {16'b0, WD[15:0]} : WD) << {Addr[1:0], 3'b000};
  assign lane   = 16'(rdata_q >> {addr_q[1:0], 3'b000});
  assign ld_ext = type_q == MEMBYTE      ? {{24{lane[7]}}, lane[7:0]} :
                  type_q == MEMBYTEU     ? {24'b0, lane[7:0]} :
                  type_q == MEMHALFWORD  ? {{16{lane[15]}}, lane} :
                  type_q == MEMHALFWORDU ? {16'b0, lane} : rdata_q;
  assign timeout = cnt_q == CNT_W'(TIMEOUT - 1);
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    type_d      = type_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    rd_valid    = 1'b0;
    RD          = 32'b0;
    excCode     = 5'd0;
    bus.bus_req = 1'b0;
    case (state_q)
      IDLE: begin
        excCode = mem_valid && fault ? (WE ? 5'd5 : 5'd4) : 5'd0;
        if (mem_valid && !fault && !requestInt) begin
          state_d = REQ;
          stall   = 1'b1;
          addr_d  = Addr;
          type_d  = MemType;
          we_d    = WE;
          be_d    = WE ? be : 4'b0000;
          wdata_d = WE ? wd_sh : 32'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        stall       = 1'b1;
        bus.bus_req = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        state_d     = timeout ? DONE : bus.bus_gnt ? RESP : REQ;
        err_d       = timeout;
      end
      RESP: begin
        stall   = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        rdata_d = bus.bus_rvalid ? bus.bus_rdata : rdata_q;
        state_d = bus.bus_rvalid || timeout ? DONE : RESP;
        err_d   = !bus.bus_rvalid && timeout;
      end
      DONE: begin
        excCode  = err_q ? 5'd7 : 5'd0;
        rd_valid = !we_q && !err_q;
        RD       = !we_q && !err_q ? ld_ext : 32'b0;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
